// File: rtl/bsram_pkg.sv
// Shared defaults, state encoding and credit helper for the BSRAM burst sequencer.
package bsram_pkg;

    localparam int unsigned BSRAM_ADDR_W = 13;
    localparam int unsigned BSRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

    // A new read may issue only if the data it returns is guaranteed a FIFO slot:
    // buffered + in-flight bytes, less the one leaving this cycle, must stay below 2.
    function automatic logic read_credit_ok(input logic [1:0] count, input logic inflight,
                                            input logic pop);
        logic [2:0] used;
        used = {1'b0, count} + {2'b00, inflight};
        return pop ? (used < 3'd3) : (used < 3'd2);
    endfunction

endpackage

// File: rtl/bsram_rd_fifo2.sv
// Two-entry FIFO holding {last, data} for read bytes returning from the RAM.
module bsram_rd_fifo2 #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              push_last,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              head_last,
    output logic [1:0]        count
);

    logic [DATA_W:0] mem_q [2];
    logic            wr_ptr_q;
    logic            rd_ptr_q;
    logic [1:0]      count_q;

    // Pointer and occupancy update; push at count 2 with pop is excluded by the issue credit.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_q ^ push;
            rd_ptr_q <= rd_ptr_q ^ pop;
            count_q  <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Entry storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {push_last, push_data};
        end
    end

    // Head of queue presented combinationally.
    always_comb begin
        head_last = mem_q[rd_ptr_q][DATA_W];
        head_data = mem_q[rd_ptr_q][DATA_W-1:0];
        count     = count_q;
    end

endmodule

// File: rtl/bsram_burst_ctrl.sv
// Burst sequencer in front of an 8Kx8 single-port BSRAM with 1-cycle read latency.
module bsram_burst_ctrl
    import bsram_pkg::*;
#(
    parameter int unsigned ADDR_W = BSRAM_ADDR_W,
    parameter int unsigned DATA_W = BSRAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              done,
    output logic              ram_ce,
    output logic              ram_wre,
    output logic              ram_oce,
    output logic              ram_reset,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic [ADDR_W-1:0] issued_rem_q, issued_rem_d;
    logic              all_issued_q, all_issued_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;
    logic              done_q, done_d;

    logic [1:0]        fifo_count;
    logic              head_last;
    logic              pop;
    logic              issue;

    bsram_rd_fifo2 #(
        .DATA_W (DATA_W)
    ) u_rd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_last (inflight_last_q),
        .push_data (ram_dout),
        .pop       (pop),
        .head_data (rd_data),
        .head_last (head_last),
        .count     (fifo_count)
    );

    // Registered state; reset aborts any burst without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            issued_rem_q    <= '0;
            all_issued_q    <= 1'b1;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remaining_q     <= remaining_d;
            issued_rem_q    <= issued_rem_d;
            all_issued_q    <= all_issued_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
        end
    end

    // Next-state, RAM strobes and handshakes. The state holds through the done cycle
    // so a new command is only seen the cycle after done.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        issued_rem_d = issued_rem_q;
        all_issued_d = all_issued_q;
        done_d       = 1'b0;
        wr_ready     = 1'b0;
        ram_ce       = 1'b0;
        ram_wre      = 1'b0;
        ram_ad       = addr_q;
        ram_din      = wr_data;
        issue        = 1'b0;

        rd_valid = (fifo_count != 2'd0);
        rd_last  = rd_valid & head_last;
        pop      = rd_valid & rd_ready & (state_q == READ);

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d       = cmd_addr;
                    remaining_d  = cmd_len;
                    issued_rem_d = cmd_len;
                    all_issued_d = 1'b0;
                    state_d      = cmd_we ? WRITE : READ;
                end
            end
            WRITE: begin
                if (done_q) begin
                    state_d = IDLE;
                end else begin
                    wr_ready = 1'b1;
                    if (wr_valid) begin
                        ram_ce      = 1'b1;
                        ram_wre     = 1'b1;
                        addr_d      = addr_q + ONE;
                        remaining_d = remaining_q - ONE;
                        done_d      = (remaining_q == '0);
                    end
                end
            end
            READ: begin
                if (done_q) begin
                    state_d = IDLE;
                end else begin
                    issue = !all_issued_q && read_credit_ok(fifo_count, inflight_q, pop);
                    if (issue) begin
                        ram_ce       = 1'b1;
                        addr_d       = addr_q + ONE;
                        issued_rem_d = issued_rem_q - ONE;
                        all_issued_d = (issued_rem_q == '0);
                    end
                    done_d = pop & head_last;
                end
            end
            default: state_d = IDLE;
        endcase

        inflight_d      = issue;
        inflight_last_d = issue & (issued_rem_q == '0);
    end

    // Status and fixed RAM controls.
    always_comb begin
        cmd_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        done      = done_q;
        ram_oce   = 1'b1;
        ram_reset = reset;
    end

endmodule

// File: tb/tb_bsram_burst_ctrl.sv
// Self-checking bench: behavioural 8Kx8 RAM plus a shadow memory as reference.
module tb_bsram_burst_ctrl;

    localparam int AW    = 13;
    localparam int DW    = 8;
    localparam int DEPTH = 8192;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_addr, cmd_len;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid, rd_ready, rd_last;
    logic [DW-1:0] rd_data;
    logic          busy, done;
    logic          ram_ce, ram_wre, ram_oce, ram_reset;
    logic [AW-1:0] ram_ad;
    logic [DW-1:0] ram_din, ram_dout;

    logic [7:0] ram     [DEPTH];
    logic [7:0] ref_mem [DEPTH];
    logic [7:0] wq [$];

    int n_vec = 0;
    int n_err = 0;

    bsram_burst_ctrl #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .busy      (busy),
        .done      (done),
        .ram_ce    (ram_ce),
        .ram_wre   (ram_wre),
        .ram_oce   (ram_oce),
        .ram_reset (ram_reset),
        .ram_ad    (ram_ad),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM, one cycle read latency.
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_wre) begin
                ram[ram_ad] <= ram_din;
                ram_dout    <= ram_din;
            end else begin
                ram_dout <= ram[ram_ad];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic we, input logic [AW-1:0] a, input logic [AW-1:0] lm1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_len   = lm1;
        @(negedge clk);
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Write len bytes from wq starting at a; gap is the percent chance of an idle cycle.
    task automatic do_write(input logic [AW-1:0] a, input int len, input int gap);
        int k;
        int t;
        logic [AW-1:0] ea;
        k = 0;
        t = 0;
        send_cmd(1'b1, a, AW'(len - 1));
        while (k < len && t < len * 8 + 32) begin
            wr_valid = ($urandom_range(0, 99) >= gap);
            wr_data  = wq[k];
            @(negedge clk);
            chk("wr_nodone", {31'd0, done}, 32'd0);
            if (wr_valid && wr_ready) begin
                ea = a + AW'(k);
                chk("wr_strobe", {30'd0, ram_ce, ram_wre}, 32'd3);
                chk("wr_ad", {19'd0, ram_ad}, {19'd0, ea});
                chk("wr_din", {24'd0, ram_din}, {24'd0, wq[k]});
                ref_mem[ea] = wq[k];
                k++;
            end else begin
                chk("wr_idle_ce", {31'd0, ram_ce}, 32'd0);
            end
            @(posedge clk);
            #1;
            t++;
        end
        wr_valid = 1'b0;
        if (k < len) chk("wr_timeout", k, len);
        @(negedge clk);
        chk("wr_done", {31'd0, done}, 32'd1);
        chk("wr_done_cmdrdy", {31'd0, cmd_ready}, 32'd0);
        chk("wr_done_ready", {31'd0, wr_ready}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("wr_done_end", {31'd0, done}, 32'd0);
        chk("wr_cmdrdy_after", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // mode 0: rd_ready held high; 1: pattern 1,0,0; 2: random.
    task automatic do_read(input logic [AW-1:0] a, input int len, input int mode, input bit lat);
        logic [8:0] expq [$];
        logic [8:0] e;
        logic [AW-1:0] ea;
        int issues;
        int pops;
        int k;
        int p;
        for (int i = 0; i < len; i++) begin
            ea = a + AW'(i);
            expq.push_back({(i == len - 1), ref_mem[ea]});
        end
        issues = 0;
        pops   = 0;
        k      = 1;
        send_cmd(1'b0, a, AW'(len - 1));
        while (expq.size() > 0 && k < len * 6 + 32) begin
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = ((k % 3) == 1);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            p = (rd_valid && rd_ready) ? 1 : 0;
            if (ram_ce) begin
                ea = a + AW'(issues);
                chk("rd_wre", {31'd0, ram_wre}, 32'd0);
                chk("rd_ad", {19'd0, ram_ad}, {19'd0, ea});
                chk("rd_credit", {31'd0, ((issues - pops - p) < 2)}, 32'd1);
                issues++;
            end
            if (lat && k <= 3) chk("rd_latency", {31'd0, rd_valid}, {31'd0, (k == 3)});
            if (mode == 0 && pops > 0) chk("rd_stream", {31'd0, rd_valid}, 32'd1);
            chk("rd_nodone", {31'd0, done}, 32'd0);
            if (p != 0) begin
                e = expq.pop_front();
                chk("rd_data", {24'd0, rd_data}, {24'd0, e[7:0]});
                chk("rd_last", {31'd0, rd_last}, {31'd0, e[8]});
                pops++;
            end
            @(posedge clk);
            #1;
            k++;
        end
        rd_ready = 1'b0;
        if (expq.size() != 0) chk("rd_timeout", expq.size(), 0);
        @(negedge clk);
        chk("rd_done", {31'd0, done}, 32'd1);
        chk("rd_done_ce", {31'd0, ram_ce}, 32'd0);
        chk("rd_done_valid", {31'd0, rd_valid}, 32'd0);
        chk("rd_issue_total", issues, len);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rd_done_end", {31'd0, done}, 32'd0);
        chk("rd_cmdrdy_after", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [AW-1:0] ra;
        int rl;
        int pops;
        int t;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset values
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_rd_last", {31'd0, rd_last}, 32'd0);
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("rst_ram_strobe", {30'd0, ram_ce, ram_wre}, 32'd0);
        chk("rst_ram_oce", {31'd0, ram_oce}, 32'd1);
        chk("rst_ram_reset", {31'd0, ram_reset}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_cmdrdy", {31'd0, cmd_ready}, 32'd1);
        chk("post_rst_ram_reset", {31'd0, ram_reset}, 32'd0);

        // Stray handshakes in IDLE must not touch the RAM
        @(posedge clk);
        #1;
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        @(negedge clk);
        chk("idle_stray_ce", {31'd0, ram_ce}, 32'd0);
        chk("idle_wr_ready", {31'd0, wr_ready}, 32'd0);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        rd_ready = 1'b0;

        // Fill the whole RAM with random bytes (full-length write, wraps)
        wq.delete();
        for (int i = 0; i < DEPTH; i++) wq.push_back(8'($urandom));
        do_write(AW'($urandom), DEPTH, 0);

        // Directed write A1..A4 at 0x0010
        wq.delete();
        for (int i = 0; i < 4; i++) wq.push_back(8'hA1 + 8'(i));
        do_write(13'h0010, 4, 0);
        chk("ram_10", {24'd0, ram[16]}, 32'hA1);
        chk("ram_11", {24'd0, ram[17]}, 32'hA2);
        chk("ram_12", {24'd0, ram[18]}, 32'hA3);
        chk("ram_13", {24'd0, ram[19]}, 32'hA4);

        do_read(13'h0010, 4, 0, 1'b1);
        do_read(13'h0010, 4, 1, 1'b0);

        // Wrapping write at 0x1FFE
        wq.delete();
        wq.push_back(8'h5A);
        wq.push_back(8'hC3);
        wq.push_back(8'h7E);
        do_write(13'h1FFE, 3, 0);
        chk("wrap_1ffe", {24'd0, ram[8190]}, 32'h5A);
        chk("wrap_1fff", {24'd0, ram[8191]}, 32'hC3);
        chk("wrap_0000", {24'd0, ram[0]}, 32'h7E);
        chk("wrap_1ffd_kept", {24'd0, ram[8189]}, {24'd0, ref_mem[8189]});
        do_read(13'h1FFE, 3, 2, 1'b0);

        // Maximum-length read
        do_read(13'h0000, DEPTH, 0, 1'b0);

        // Random short bursts with random flow control
        for (int n = 0; n < 8; n++) begin
            ra = AW'($urandom);
            rl = $urandom_range(1, 20);
            wq.delete();
            for (int i = 0; i < rl; i++) wq.push_back(8'($urandom));
            do_write(ra, rl, 30);
            do_read(AW'(ra + AW'($urandom_range(0, 4))), $urandom_range(1, 24), 2, 1'b0);
        end

        // Reset in the middle of a read after two bytes
        send_cmd(1'b0, 13'h0010, 13'd7);
        rd_ready = 1'b1;
        pops = 0;
        t = 0;
        while (pops < 2 && t < 40) begin
            @(negedge clk);
            if (rd_valid && rd_ready) begin
                chk("abort_data", {24'd0, rd_data}, {24'd0, ref_mem[16 + pops]});
                pops++;
            end
            @(posedge clk);
            #1;
            t++;
        end
        if (pops < 2) chk("abort_timeout", pops, 2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        rd_ready = 1'b0;
        @(negedge clk);
        chk("abort_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_cmdrdy", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        do_read(13'h0013, 1, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bsram_burst_ctrl.md
# bsram_burst_ctrl

Burst sequencer sitting directly upstream of the 8K×8 single-port block RAM macro (`Gowin_SP`: 1-cycle read latency, bypass read mode). It accepts a command (start address, length, direction) over a valid/ready handshake. For writes, it streams bytes from a valid/ready write channel into the RAM. For reads, it streams RAM bytes out on a back-pressured valid/ready read channel, using a 2-entry output FIFO so no data is lost when the consumer stalls.

## Interface
Parameters:
- ADDR_W, 13, RAM address width; also the burst-length field width.
- DATA_W, 8, data width.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high. Also drives ram_reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high exactly when state is IDLE.
- cmd_we  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_W  start address.
- cmd_len  in  ADDR_W  byte count minus 1; covers 1..8192 bytes.
- wr_valid  in  1  write byte offered.
- wr_ready  out  1  high only in WRITE.
- wr_data  in  DATA_W  write byte.
- rd_valid  out  1  read byte available; comes from FIFO head.
- rd_ready  in  1  consumer accepts the read byte.
- rd_data  out  DATA_W  read byte.
- rd_last  out  1  marks the final byte of a read burst.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on burst completion.
- ram_ce, ram_wre  out  1  to RAM CE / WRE.
- ram_oce  out  1  tied to 1.
- ram_reset  out  1  equals reset.
- ram_ad  out  ADDR_W  to RAM AD.
- ram_din  out  DATA_W  to RAM DI.
- ram_dout  in  DATA_W  from RAM DO.

## Operation
States: IDLE, WRITE, READ.

IDLE
- On cmd_valid, latch addr ← cmd_addr, remaining ← cmd_len, issued_rem ← cmd_len.
- Go to WRITE if cmd_we = 1, else READ.

WRITE
- wr_ready = 1.
- When wr_valid is high, in the same cycle: ram_ce = 1, ram_wre = 1, ram_ad = addr, ram_din = wr_data. Then addr += 1 and remaining −= 1.
- When a byte is accepted with remaining = 0, go to IDLE and pulse done.

READ
- A read issues (ram_ce = 1, ram_wre = 0, ram_ad = addr) when reads remain unissued AND (fifo_count + inflight − pop) < 2, where pop = rd_valid & rd_ready.
- inflight is a 1-bit register set by an issue. The cycle after an issue, ram_dout is pushed into the FIFO.
- Each FIFO entry carries a last flag, set for the byte issued when issued_rem = 0.
- When the last byte pops, go to IDLE and pulse done.

General rules:
- Address arithmetic is modulo 2^ADDR_W; 0x1FFF wraps to 0x0000 with no error.
- ram_ce = 0 whenever no access occurs.
- wr_valid outside WRITE and rd_ready outside READ are ignored; no RAM access results.
- A new command is never accepted in the cycle done pulses, because state is still the completing state. It can be accepted the cycle after.

## Timing
- Reset values: state IDLE, FIFO empty, inflight 0. Outputs: rd_valid 0, rd_last 0, done 0, busy 0, wr_ready 0, ram_ce 0, ram_wre 0. cmd_ready = 1 from the first cycle after reset deasserts.
- Reset mid-burst aborts immediately: FIFO flushed, no done pulse, partial writes remain in RAM.
- Write throughput: 1 byte/cycle. ram_ce/ram_wre/ram_ad/ram_din are combinational from wr_valid in WRITE.
- Read latency: command accepted on edge c → first issue in cycle c+1 → rd_valid high in cycle c+3.
- Read throughput: sustained 1 byte/cycle while rd_ready is held high.
- Read back-pressure: rd_ready low stops new issues once count + inflight = 2. No byte is ever dropped or duplicated.
- done is registered and asserts for exactly 1 cycle. cmd_ready rises in the cycle after done.

## Structure
- Package bsram_pkg: ADDR_W/DATA_W defaults and the state enum {IDLE, WRITE, READ}.
- Sub-module bsram_rd_fifo2: 2-entry FIFO of {last, data} with push/pop/count, synchronous reset. Simultaneous push and pop at count 2 cannot occur, by the credit rule.
- Top level connects bsram_burst_ctrl directly to `Gowin_SP`. The bench uses a behavioural 8K×8 model with 1-cycle read latency.

## Test plan
- Write 4 bytes 0xA1..0xA4 at 0x0010 with wr_valid continuous → RAM[0x10..0x13] = A1..A4; done pulses 1 cycle after the 4th accept.
- Read 4 bytes at 0x0010 with rd_ready = 1 → rd_data A1, A2, A3, A4 on consecutive cycles; first rd_valid 2 cycles after entering READ; rd_last on A4 only.
- Same read with rd_ready toggling 1,0,0,1,… → the byte sequence is identical, no gaps or duplicates, and ram_ce never issues with count + inflight = 2.
- Write 3 bytes at 0x1FFE → addresses 0x1FFE, 0x1FFF, 0x0000 written (wrap).
- Read burst of length 8192 (cmd_len = 0x1FFF) → exactly 8192 bytes, rd_last only on the last.
- Reset asserted mid-read after 2 bytes → rd_valid 0 next cycle, no done, cmd_ready 1 after reset. A following read of 1 byte returns the correct data.
